// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the recurrence generator, its ALU and
// the display logic downstream.
//   state_e  - generator FSM state encoding
//   OP_*     - opcode values presented on the op input

package seq_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

endpackage

// File: rtl/seq_alu.sv
// seq_alu: combinational operator for one recurrence step, y = a OP b.
//   a, b    in  WIDTH  operands (a = older term, b = newer term)
//   op      in  3      opcode, unsupported values give y = 0
//   y       out WIDTH  result truncated to WIDTH bits
//   carry   out 1      ADD carried out of WIDTH bits (0 for other ops)
//   borrow  out 1      SUB with a < b (0 for other ops)
//   zero    out 1      y is all zeros

module seq_alu
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             borrow,
   output logic             zero
);

   logic [WIDTH:0] r;

   always_comb begin
      r      = '0;
      carry  = 1'b0;
      borrow = 1'b0;
      case (op)
         OP_ADD: begin
            r     = {1'b0, a} + {1'b0, b};
            carry = r[WIDTH];
         end
         OP_SUB: begin
            // the extra MSB of an unsigned difference is set exactly when a < b
            r      = {1'b0, a} - {1'b0, b};
            borrow = r[WIDTH];
         end
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         default: r = '0;
      endcase
   end

   assign y    = r[WIDTH-1:0];
   assign zero = (y == '0);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: two-term recurrence generator f(n) = f(n-2) OP f(n-1).
// Advances on a step button rising edge, or on an internal prescaled tick
// when auto_en is set. Halts on ADD carry / SUB borrow or at MAX_STEPS.
//   clk       in   system clock
//   rst       in   async active-high reset
//   step_btn  in   step button level (already synchronous)
//   auto_en   in   1 = advance on tick, 0 = advance on button edge
//   clr       in   synchronous clear back to IDLE
//   op        in   opcode (see seq_gen_pkg)
//   d0, d1    in   seeds for prev / f, captured on the first advance
//   f, prev   out  current / previous term
//   count     out  terms produced since load
//   ovf       out  sticky carry/borrow flag
//   halted    out  generator is in HALT
//
// state  | meaning
// IDLE   | waiting for a button edge to load the seeds
// RUN    | advancing one term per adv
// HALT   | frozen after overflow or step limit; only clr/rst leave

module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int WIDTH     = 7,
   parameter int CNT_W     = 8,
   parameter int MAX_STEPS = 255,
   parameter int DIV       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_btn,
   input  logic             auto_en,
   input  logic             clr,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] prev,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             halted
);

   localparam int PW = $clog2(DIV);

   state_e           state_q, state_d;
   logic             btn_q;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] f_q, f_d, prev_q, prev_d;
   logic [CNT_W-1:0] count_q, count_d, count_inc;
   logic             ovf_q, ovf_d;

   logic             step_p, tick, adv;
   logic [WIDTH-1:0] alu_y;
   logic             alu_carry, alu_borrow, unused_alu_zero;

   seq_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (prev_q),
      .b      (f_q),
      .op     (op),
      .y      (alu_y),
      .carry  (alu_carry),
      .borrow (alu_borrow),
      .zero   (unused_alu_zero)
   );

   assign step_p    = step_btn & ~btn_q;
   assign tick      = (state_q == S_RUN) && auto_en && (presc_q == PW'(DIV - 1));
   // IDLE always loads on a button edge, even in auto mode
   assign adv       = (state_q == S_IDLE) ? step_p : (auto_en ? tick : step_p);
   assign count_inc = count_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      prev_d  = prev_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      presc_d = '0;

      // prescaler runs only in RUN with auto_en; otherwise held at 0 so a
      // fresh RUN or re-enabled auto mode always waits a full DIV period
      if (state_q == S_RUN && auto_en) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end

      if (clr) begin
         state_d = S_IDLE;
         f_d     = '0;
         prev_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (adv) begin
                  prev_d  = d0;
                  f_d     = d1;
                  count_d = CNT_W'(1);
                  ovf_d   = 1'b0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (adv) begin
                  if (alu_carry || alu_borrow) begin
                     ovf_d   = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     prev_d  = f_q;
                     f_d     = alu_y;
                     count_d = count_inc;
                     if (count_inc == CNT_W'(MAX_STEPS)) begin
                        state_d = S_HALT;
                     end
                  end
               end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         btn_q   <= 1'b0;
         presc_q <= '0;
         f_q     <= '0;
         prev_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         btn_q   <= step_btn;
         presc_q <= presc_d;
         f_q     <= f_d;
         prev_q  <= prev_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign f      = f_q;
   assign prev   = prev_q;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;

   localparam int WIDTH     = 7;
   localparam int CNT_W     = 8;
   localparam int MAX_STEPS = 255;
   localparam int DIV       = 4;
   localparam int MASK      = (1 << WIDTH) - 1;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             step_btn = 1'b0;
   logic             auto_en = 1'b0;
   logic             clr = 1'b0;
   logic [2:0]       op = 3'd0;
   logic [WIDTH-1:0] d0 = '0;
   logic [WIDTH-1:0] d1 = '0;
   logic [WIDTH-1:0] f, prev;
   logic [CNT_W-1:0] count;
   logic             ovf, halted;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: plain integers, one call per clock edge
   int m_f, m_prev, m_count, m_mode, m_phase;
   bit m_ovf, m_btn;

   seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS), .DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .step_btn (step_btn),
      .auto_en  (auto_en),
      .clr      (clr),
      .op       (op),
      .d0       (d0),
      .d1       (d1),
      .f        (f),
      .prev     (prev),
      .count    (count),
      .ovf      (ovf),
      .halted   (halted)
   );

   initial forever #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_f = 0; m_prev = 0; m_count = 0; m_mode = M_IDLE; m_phase = 0;
      m_ovf = 0; m_btn = 0;
   endtask

   task automatic model_step(input bit btn, input bit c);
      bit sp, adv, bad;
      int r;
      sp    = btn && !m_btn;
      m_btn = btn;
      if (c) begin
         m_f = 0; m_prev = 0; m_count = 0; m_ovf = 0; m_mode = M_IDLE; m_phase = 0;
         return;
      end
      case (m_mode)
         M_IDLE: if (sp) begin
            m_prev = int'(d0); m_f = int'(d1); m_count = 1; m_ovf = 0;
            m_mode = M_RUN; m_phase = 0;
         end
         M_RUN: begin
            adv     = auto_en ? (m_phase == DIV - 1) : sp;
            m_phase = auto_en ? (m_phase + 1) % DIV : 0;
            if (adv) begin
               bad = 0;
               case (int'(op))
                  0: begin r = m_prev + m_f; bad = (r > MASK); end
                  1: begin bad = (m_prev < m_f); r = m_prev - m_f; end
                  2: r = m_prev & m_f;
                  3: r = m_prev | m_f;
                  4: r = m_prev ^ m_f;
                  default: r = 0;
               endcase
               if (bad) begin
                  m_ovf = 1; m_mode = M_HALT;
               end else begin
                  m_prev = m_f; m_f = r; m_count++;
                  if (m_count == MAX_STEPS) m_mode = M_HALT;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, ".f"},      int'(f),      m_f);
      check_val({tag, ".prev"},   int'(prev),   m_prev);
      check_val({tag, ".count"},  int'(count),  m_count);
      check_val({tag, ".ovf"},    int'(ovf),    int'(m_ovf));
      check_val({tag, ".halted"}, int'(halted), int'(m_mode == M_HALT));
   endtask

   // called 1 time unit after a posedge: drive, predict, clock, compare
   task automatic cyc(input bit btn, input bit c);
      step_btn = btn;
      clr      = c;
      model_step(btn, c);
      @(posedge clk);
      #1;
      compare_all("cyc");
   endtask

   task automatic press();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      check_val("rst_async.f",      int'(f),      0);
      check_val("rst_async.prev",   int'(prev),   0);
      check_val("rst_async.count",  int'(count),  0);
      check_val("rst_async.ovf",    int'(ovf),    0);
      check_val("rst_async.halted", int'(halted), 0);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int fib[10];
      int xr[5];
      fib = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
      xr  = '{6, 5, 3, 6, 5};
      model_reset();
      #23;
      compare_all("reset");
      rst = 1'b0;

      // 1: ADD Fibonacci up to carry-out
      op = 3'd0; d0 = 7'd0; d1 = 7'd1; auto_en = 1'b0;
      press();
      check_val("fib_load.f", int'(f), 1);
      check_val("fib_load.count", int'(count), 1);
      for (int i = 0; i < 10; i++) begin
         press();
         check_val("fib_f", int'(f), fib[i]);
      end
      check_val("fib_count", int'(count), 11);
      press();
      check_val("fib_ovf", int'(ovf), 1);
      check_val("fib_halted", int'(halted), 1);
      check_val("fib_hold.f", int'(f), 89);
      check_val("fib_hold.prev", int'(prev), 55);
      press();
      check_val("halt_ignores_step.f", int'(f), 89);

      // 2: held button gives exactly one advance
      cyc(1'b0, 1'b1);
      check_val("clr_from_halt.halted", int'(halted), 0);
      d0 = 7'd1; d1 = 7'd1;
      press();
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check_val("held_btn.f", int'(f), 2);
      check_val("held_btn.count", int'(count), 2);

      // 3: auto mode, one advance per DIV cycles; auto_en=0 freezes
      cyc(1'b0, 1'b1);
      d0 = 7'd0; d1 = 7'd1;
      press();
      auto_en = 1'b1;
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
      check_val("auto.f", int'(f), 3);
      check_val("auto.count", int'(count), 4);
      auto_en = 1'b0;
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
      check_val("auto_off.f", int'(f), 3);

      // 4: XOR period 3
      cyc(1'b0, 1'b1);
      op = 3'd4; d0 = 7'd5; d1 = 7'd3;
      press();
      for (int i = 0; i < 5; i++) begin
         press();
         check_val("xor_f", int'(f), xr[i]);
      end
      check_val("xor_ovf", int'(ovf), 0);

      // 5: SUB borrow
      cyc(1'b0, 1'b1);
      op = 3'd1; d0 = 7'd10; d1 = 7'd3;
      press();
      press();
      check_val("sub.f", int'(f), 7);
      check_val("sub.prev", int'(prev), 3);
      press();
      check_val("sub_borrow.ovf", int'(ovf), 1);
      check_val("sub_borrow.halted", int'(halted), 1);
      check_val("sub_borrow.f", int'(f), 7);

      // 6: clr beats step; async reset mid-RUN
      cyc(1'b0, 1'b1);
      op = 3'd0; d0 = 7'd0; d1 = 7'd1;
      press();
      press();
      cyc(1'b1, 1'b1);
      check_val("clr_wins.f", int'(f), 0);
      check_val("clr_wins.count", int'(count), 0);
      check_val("clr_wins.halted", int'(halted), 0);
      cyc(1'b0, 1'b0);
      press();
      press();
      check_val("pre_rst.count", int'(count), 2);
      rst_pulse();
      press();
      check_val("reload.f", int'(f), 1);
      check_val("reload.count", int'(count), 1);

      // step limit: XOR never overflows, so it runs to MAX_STEPS
      cyc(1'b0, 1'b1);
      op = 3'd4; d0 = 7'd5; d1 = 7'd3;
      press();
      auto_en = 1'b1;
      for (int i = 0; i < 1020; i++) cyc(1'b0, 1'b0);
      check_val("limit.count", int'(count), MAX_STEPS);
      check_val("limit.halted", int'(halted), 1);
      check_val("limit.ovf", int'(ovf), 0);
      auto_en = 1'b0;

      // randomized traffic against the model
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) auto_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)  op = 3'($urandom_range(0, 7));
         d0 = WIDTH'($urandom_range(0, MASK));
         d1 = WIDTH'($urandom_range(0, MASK));
         if ($urandom_range(0, 299) == 0) rst_pulse();
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
